imem_loader: RTL

//  Program loader: initiator on the instruction-memory write port (writeEnable/writeAddress/writeData).

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader_if.sv | 31 +++
 rtl/imem_loader_timeout.sv | 35 +++
 rtl/imem_loader.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Contents: loader FSM state encoding, bytes-per-word and header width constants,
//           and a helper that says which states accept bytes from the UART.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    WRITE,
    DONE,
    ERROR
  } ldr_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_WIDTH      = 16;

  // States in which the loader will take a byte from the RX stream.
  function automatic logic accepts_bytes(input ldr_state_t s);
    return (s == LEN0) || (s == LEN1) || (s == DATA);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Loader-side bundle: control/status, UART RX byte stream and memory write port.
// master : the loader (drives rx_ready, write port, busy/done/error/words_loaded).
// slave  : the environment (drives start, rx_valid, rx_data; observes the rest).
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  writeEnable;
  logic [ADDR_WIDTH-1:0] writeAddress;
  logic [DATA_WIDTH-1:0] writeData;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [ADDR_WIDTH:0]   words_loaded;

  modport master (
    input  start, rx_valid, rx_data,
    output rx_ready, writeEnable, writeAddress, writeData,
    output busy, done, error, words_loaded
  );

  modport slave (
    output start, rx_valid, rx_data,
    input  rx_ready, writeEnable, writeAddress, writeData,
    input  busy, done, error, words_loaded
  );
endinterface

// File: rtl/imem_loader_timeout.sv
// Inter-byte idle timer: counts enabled cycles, saturates at TIMEOUT_CYCLES.
// Ports: clock/reset; clear_i zeroes the count (wins over enable_i);
//        enable_i advances it; expired_o is high while the count equals TIMEOUT_CYCLES.
module ldr_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q, count_d;

  assign expired_o = (count_q == CW'(TIMEOUT_CYCLES));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Program loader: parses a 16-bit little-endian word count from the UART byte stream,
// assembles little-endian 32-bit words and writes them to instruction memory from address 0.
// Ports: clock, reset (async, active-high); bus (imem_loader_if.master) carrying start,
//        rx_valid/rx_data/rx_ready, writeEnable/writeAddress/writeData, busy/done/error/words_loaded.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic          clock,
  input  logic          reset,
  imem_loader_if.master bus
);
  // Largest legal word count: the whole memory.
  localparam logic [31:0]         DEPTH    = 32'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] WCNT_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [1:0]          LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  ldr_state_t            state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;

  logic rx_ready;
  logic xfer;
  logic to_clear;
  logic to_enable;
  logic to_expired;

  // Byte acceptance is a pure decode of the registered state.
  assign rx_ready = accepts_bytes(state_q);
  assign xfer     = bus.rx_valid && rx_ready;

  // Idle timer restarts on every accepted byte and on any state change,
  // and only runs while waiting for the length high byte or data bytes.
  assign to_clear  = xfer || (state_d != state_q);
  assign to_enable = (state_q == LEN1) || (state_q == DATA);

  ldr_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (to_clear),
    .enable_i (to_enable),
    .expired_o(to_expired)
  );

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    addr_d     = addr_q;
    words_d    = words_q;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (bus.start) begin
          state_d    = LEN0;
          words_d    = '0;
          addr_d     = '0;
          byte_idx_d = '0;
        end
      end

      LEN0: begin
        if (xfer) begin
          len_lo_d = bus.rx_data;
          state_d  = LEN1;
        end
      end

      LEN1: begin
        if (xfer) begin
          len_d      = {bus.rx_data, len_lo_q};
          byte_idx_d = '0;
          if ({bus.rx_data, len_lo_q} == '0) begin
            state_d = DONE;
          end else if ({16'd0, bus.rx_data, len_lo_q} > DEPTH) begin
            state_d = ERROR;
          end else begin
            state_d = DATA;
          end
        end else if (to_expired) begin
          state_d = ERROR;
        end
      end

      DATA: begin
        if (xfer) begin
          // Shift right so the first byte ends up in the least significant lane.
          word_d = {bus.rx_data, word_q[DATA_WIDTH-1:8]};
          if (byte_idx_q == LAST_BYTE) begin
            byte_idx_d = '0;
            state_d    = WRITE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end else if (to_expired) begin
          state_d = ERROR;
        end
      end

      WRITE: begin
        words_d = words_q + WCNT_ONE;
        if ((32'(words_q) + 32'd1) == 32'(len_q)) begin
          // Address is left on the last written word so a full-depth load never wraps.
          state_d = DONE;
        end else begin
          addr_d  = addr_q + ADDR_ONE;
          state_d = DATA;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      len_lo_q   <= '0;
      len_q      <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
    end
  end

  // All outputs decode registered state, so reset clears them asynchronously.
  assign bus.rx_ready     = rx_ready;
  assign bus.writeEnable  = (state_q == WRITE);
  assign bus.writeAddress = (state_q == WRITE) ? addr_q : '0;
  assign bus.writeData    = (state_q == WRITE) ? word_q : '0;
  assign bus.busy         = (state_q == LEN0) || (state_q == LEN1) ||
                            (state_q == DATA) || (state_q == WRITE);
  assign bus.done         = (state_q == DONE);
  assign bus.error        = (state_q == ERROR);
  assign bus.words_loaded = words_q;
endmodule
